// File: rtl/round_arbiter.sv
// Referee front end for the two-player reaction game: synchronises the buttons, runs the
// lights-off random delay and lights-on window, and reports who pushed first.
module round_arbiter #(
   parameter logic [15:0] DELAY_MIN  = 16'd1000,
   parameter int unsigned DELAY_BITS = 10,
   parameter logic [15:0] HOLDOFF    = 16'd500,
   parameter logic [15:0] TIMEOUT    = 16'd4000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pb_l,
   input  logic       pb_r,
   output logic       leds_on,
   output logic       winrnd,
   output logic       right,
   output logic       tie,
   output logic [1:0] dbg_state_o
);

   // Result contract: winrnd is a single-cycle pulse with no back-pressure; right, tie and
   // leds_on are valid in that same cycle, and right/tie then hold until the next pulse.

   if (DELAY_BITS < 1 || DELAY_BITS > 16) begin : g_bad_bits
      $error("round_arbiter: DELAY_BITS must be in 1..16");
   end
   if (32'(DELAY_MIN) + (32'd1 << DELAY_BITS) - 32'd1 > 32'd65535) begin : g_bad_span
      $error("round_arbiter: DELAY_MIN + 2**DELAY_BITS - 1 does not fit in 16 bits");
   end
   if (LFSR_SEED == 16'd0) begin : g_bad_seed
      $error("round_arbiter: LFSR_SEED must be nonzero");
   end

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_LIGHTS = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  s1_q, s2_q, s2p_q;    // bit 0 = left, bit 1 = right
   logic        leds_q, leds_d;
   logic        win_q, win_d;
   logic        right_q, right_d;
   logic        tie_q, tie_d;

   logic press_l, press_r, any_press, any_held;

   assign press_l   = s2_q[0] & ~s2p_q[0];
   assign press_r   = s2_q[1] & ~s2p_q[1];
   assign any_press = press_l | press_r;
   assign any_held  = s2_q[0] | s2_q[1];
   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HOLD;
         cnt_q   <= HOLDOFF;
         lfsr_q  <= LFSR_SEED;
         s1_q    <= 2'b00;
         s2_q    <= 2'b00;
         s2p_q   <= 2'b00;
         leds_q  <= 1'b0;
         win_q   <= 1'b0;
         right_q <= 1'b0;
         tie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         s1_q    <= {pb_r, pb_l};
         s2_q    <= s1_q;
         s2p_q   <= s2_q;
         leds_q  <= leds_d;
         win_q   <= win_d;
         right_q <= right_d;
         tie_q   <= tie_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (any_held) begin
               cnt_d = HOLDOFF;
            end else if (cnt_q == 16'd0) begin
               cnt_d   = DELAY_MIN + 16'(lfsr_q[DELAY_BITS-1:0]);
               state_d = ST_DELAY;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DELAY: begin
            // A press on the last delay cycle still counts as a jump.
            if (any_press) begin
               cnt_d   = HOLDOFF;
               state_d = ST_RESULT;
            end else if (cnt_q == 16'd0) begin
               cnt_d   = TIMEOUT;
               state_d = ST_LIGHTS;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_LIGHTS: begin
            if (any_press) begin
               cnt_d   = HOLDOFF;
               state_d = ST_RESULT;
            end else if (cnt_q == 16'd0) begin
               cnt_d   = HOLDOFF;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RESULT: begin
            cnt_d   = HOLDOFF;
            state_d = ST_HOLD;
         end
         default: begin
            cnt_d   = HOLDOFF;
            state_d = ST_HOLD;
         end
      endcase
   end

   always_comb begin
      leds_d  = leds_q;
      win_d   = 1'b0;
      right_d = right_q;
      tie_d   = tie_q;
      case (state_q)
         ST_HOLD: begin
            leds_d = 1'b0;
         end
         ST_DELAY: begin
            leds_d = 1'b0;
            if (any_press) begin
               win_d   = 1'b1;
               right_d = press_r & ~press_l;
               tie_d   = press_r & press_l;
            end else if (cnt_q == 16'd0) begin
               leds_d = 1'b1;
            end
         end
         ST_LIGHTS: begin
            leds_d = 1'b1;
            if (any_press) begin
               win_d   = 1'b1;
               right_d = press_r & ~press_l;
               tie_d   = press_r & press_l;
            end else if (cnt_q == 16'd0) begin
               leds_d = 1'b0;
            end
         end
         ST_RESULT: begin
            leds_d = 1'b0;
         end
         default: begin
            leds_d  = 1'b0;
            right_d = 1'b0;
            tie_d   = 1'b0;
         end
      endcase
   end

   assign leds_on     = leds_q;
   assign winrnd      = win_q;
   assign right       = right_q;
   assign tie         = tie_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter: expected {leds_on,right,tie} per round go into a queue
// that a negedge monitor drains whenever winrnd is seen.
module tb_round_arbiter;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [1:0]  S_HOLD = 2'd0, S_DELAY = 2'd1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pb_l = 1'b0;
   logic       pb_r = 1'b0;
   logic       leds_on, winrnd, right, tie;
   logic [1:0] dbg_state;

   logic [2:0]  exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] m_lfsr, m_prev;

   round_arbiter #(
      .DELAY_MIN(16'd4), .DELAY_BITS(3), .HOLDOFF(16'd5), .TIMEOUT(16'd20), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .pb_l(pb_l), .pb_r(pb_r),
      .leds_on(leds_on), .winrnd(winrnd), .right(right), .tie(tie),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Reference LFSR; m_prev is the value the DUT used in the cycle before the last edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr <= SEED;
         m_prev <= SEED;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= lfsr_step(m_lfsr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && winrnd === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: winrnd with {leds,right,tie}=%b, none expected",
                     {leds_on, right, tie});
         end else begin
            chk("sb_result", {29'd0, leds_on, right, tie}, {29'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_leds(input logic v, input int budget, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (leds_on !== v && k < budget);
      chk($sformatf("wait_leds_%0b", v), {31'd0, leds_on}, {31'd0, v});
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (dbg_state !== s && k < budget);
      chk("wait_state", {30'd0, dbg_state}, {30'd0, s});
   endtask

   task automatic wait_win(input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (winrnd !== 1'b1 && k < budget);
      chk("wait_winrnd", {31'd0, winrnd}, 32'd1);
   endtask

   initial begin
      int          k_on, k_off, r1, r;
      logic [15:0] t;

      t = SEED;
      for (int i = 0; i < 5; i++) t = lfsr_step(t);
      r1 = int'(t[2:0]);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_outputs", {28'd0, leds_on, winrnd, right, tie}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, {30'd0, S_HOLD});
      #2 rst = 1'b0;

      // 1: free-running round, lights on then timeout, no winrnd
      wait_leds(1'b1, 100, k_on);
      chk("t1_on_edge", k_on, 11 + r1);
      wait_leds(1'b0, 100, k_off);
      chk("t1_off_edge", k_on + k_off, 32 + r1);
      chk("t1_back_hold", {30'd0, dbg_state}, {30'd0, S_HOLD});

      // 2: right press 3 cycles into lights
      wait_leds(1'b1, 100, k_on);
      repeat (3) @(negedge clk);
      pb_r = 1'b1;
      exp_q.push_back(3'b110);
      @(negedge clk);
      chk("t2_win_lat1", {31'd0, winrnd}, 32'd0);
      @(negedge clk);
      chk("t2_win_lat2", {31'd0, winrnd}, 32'd0);
      @(negedge clk);
      chk("t2_win_lat3", {31'd0, winrnd}, 32'd1);
      pb_r = 1'b0;
      @(negedge clk);
      chk("t2_pulse_end", {31'd0, winrnd}, 32'd0);
      chk("t2_leds_off", {31'd0, leds_on}, 32'd0);
      chk("t2_right_held", {31'd0, right}, 32'd1);

      // 3: left jumps the light early in DELAY
      wait_state(S_DELAY, 100);
      pb_l = 1'b1;
      exp_q.push_back(3'b000);
      wait_win(20);
      pb_l = 1'b0;

      // Press decided on the final delay cycle: still a jump
      wait_state(S_DELAY, 100);
      r = int'(m_prev[2:0]);
      repeat (2 + r) @(negedge clk);
      pb_r = 1'b1;
      exp_q.push_back(3'b010);
      wait_win(20);
      pb_r = 1'b0;

      // Press decided one cycle later: first lights-on cycle
      wait_state(S_DELAY, 100);
      r = int'(m_prev[2:0]);
      repeat (3 + r) @(negedge clk);
      pb_l = 1'b1;
      exp_q.push_back(3'b100);
      wait_win(20);
      pb_l = 1'b0;

      // 4: tie during lights, then held right blocks the next round
      wait_leds(1'b1, 100, k_on);
      pb_l = 1'b1;
      pb_r = 1'b1;
      exp_q.push_back(3'b101);
      wait_win(20);
      pb_l = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_held_hold", {30'd0, dbg_state}, {30'd0, S_HOLD});
      chk("t4_held_leds", {31'd0, leds_on}, 32'd0);
      pb_r = 1'b0;
      repeat (7) @(negedge clk);
      chk("t4_release_hold", {30'd0, dbg_state}, {30'd0, S_HOLD});
      @(negedge clk);
      chk("t4_release_delay", {30'd0, dbg_state}, {30'd0, S_DELAY});

      // 5: right rises in RESULT and is held; level never triggers; later left edge decides
      wait_leds(1'b1, 100, k_on);
      pb_l = 1'b1;
      exp_q.push_back(3'b100);
      wait_win(20);
      pb_l = 1'b0;
      pb_r = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_held_hold", {30'd0, dbg_state}, {30'd0, S_HOLD});
      pb_r = 1'b0;
      wait_leds(1'b1, 100, k_on);
      pb_l = 1'b1;
      exp_q.push_back(3'b100);
      wait_win(20);
      pb_l = 1'b0;

      // 6: right round to set right=1, then reset between press and winrnd
      wait_leds(1'b1, 100, k_on);
      pb_r = 1'b1;
      exp_q.push_back(3'b110);
      wait_win(20);
      pb_r = 1'b0;
      wait_leds(1'b1, 100, k_on);
      pb_r = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_no_win_yet", {31'd0, winrnd}, 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("t6_async_clear", {28'd0, leds_on, winrnd, right, tie}, 32'd0);
      pb_r = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      wait_leds(1'b1, 100, k_on);
      chk("t6_restart_on_edge", k_on, 11 + r1);
      repeat (30) @(negedge clk);
      chk("t6_idle_leds", {31'd0, leds_on}, 32'd0);

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
